// File: rtl/io_input_capture.sv
`default_nettype none
// ============================================================================
// Module   : io_input_capture
// Purpose  : Captures a switch/key word when a debounced apply button is
//            pressed and buffers captured words in a small FIFO that a
//            downstream DMA drains with a valid/ready handshake.
//
// Ports    : clock      - system clock, all state updates on rising edge
//            init_flag  - synchronous active-high reset
//            raw_btn    - asynchronous apply-button level (active-high)
//            raw_in     - asynchronous switch/key levels [DATA_W-1:0]
//            out_valid  - FIFO holds at least one word
//            out_ready  - downstream accepts the head word this cycle
//            out_data   - FIFO head word, zero when empty
//            out_count  - number of words currently held
//            overflow   - sticky: a capture was dropped on a full FIFO
//
// Revision : 1.0 - initial release
// ============================================================================
module io_input_capture #(
  parameter int DATA_W          = 22,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                          clock,
  input  logic                          init_flag,
  input  logic                          raw_btn,
  input  logic [DATA_W-1:0]             raw_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [$clog2(FIFO_DEPTH):0]   out_count,
  output logic                          overflow
);

  localparam int                C_PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [7:0]        C_CNT_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [C_PTR_W:0]  C_FULL_COUNT = (C_PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_WAIT_PRESS   = 2'd1,
    S_PRESSED      = 2'd2,
    S_WAIT_RELEASE = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Two-flop synchronizers. Nothing downstream looks at raw_btn/raw_in.
  // --------------------------------------------------------------------------
  logic              r_btn_meta;
  logic              r_btn_s;
  logic [DATA_W-1:0] r_in_meta;
  logic [DATA_W-1:0] r_in_s;

  always_ff @(posedge clock) begin
    if (init_flag) begin
      r_btn_meta <= 1'b0;
      r_btn_s    <= 1'b0;
      r_in_meta  <= '0;
      r_in_s     <= '0;
    end else begin
      r_btn_meta <= raw_btn;
      r_btn_s    <= r_btn_meta;
      r_in_meta  <= raw_in;
      r_in_s     <= r_in_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce FSM: state register
  // --------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       w_push;

  always_ff @(posedge clock) begin
    if (init_flag) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce FSM: next state, stable counter and push strobe
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_btn_s) begin
          w_state_nxt = S_WAIT_PRESS;
          w_cnt_nxt   = 8'd1;
        end
      end
      S_WAIT_PRESS: begin
        if (!r_btn_s) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end else if (r_cnt == C_CNT_LAST) begin
          // Press accepted: the only place a push is ever generated, so a
          // long hold in PRESSED cannot produce a second capture.
          w_state_nxt = S_PRESSED;
          w_push      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_PRESSED: begin
        if (!r_btn_s) begin
          w_state_nxt = S_WAIT_RELEASE;
          w_cnt_nxt   = 8'd1;
        end
      end
      S_WAIT_RELEASE: begin
        if (r_btn_s) begin
          w_state_nxt = S_PRESSED;
          w_cnt_nxt   = 8'd0;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Push stage: latch the synchronized word in the accepting cycle and write
  // it to the FIFO on the following edge. Reset clears a pending push so an
  // interrupted press never lands in the FIFO.
  // --------------------------------------------------------------------------
  logic              r_push;
  logic [DATA_W-1:0] r_push_data;

  always_ff @(posedge clock) begin
    if (init_flag) begin
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_push <= w_push;
      if (w_push) begin
        r_push_data <= r_in_s;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_PTR_W:0]   r_count;
  logic               r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr_en;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_FULL_COUNT);
  // Pop is qualified by non-empty, which also gives the no-bypass behaviour
  // when a push and a ready coincide on an empty FIFO.
  assign w_pop   = !w_empty && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_wr_en = r_push && (!w_full || w_pop);
  assign w_drop  = r_push && w_full && !w_pop;

  // Storage has no reset; out_data is masked while empty instead.
  always_ff @(posedge clock) begin
    if (!init_flag && w_wr_en) begin
      r_mem[r_wr_ptr] <= r_push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (init_flag) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: derived only from registered FIFO state
  // --------------------------------------------------------------------------
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign out_count = r_count;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_io_input_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_input_capture
// Purpose  : Directed self-checking bench for io_input_capture. Expected
//            FIFO contents are kept in a scoreboard queue filled as presses
//            are driven and drained as words are popped.
//
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_input_capture;

  localparam int DATA_W          = 22;
  localparam int DEBOUNCE_CYCLES = 16;
  localparam int FIFO_DEPTH      = 8;
  localparam int CNT_W           = $clog2(FIFO_DEPTH) + 1;
  localparam int HOLD            = 24;
  localparam int SETTLE          = 24;

  logic              clock;
  logic              init_flag;
  logic              raw_btn;
  logic [DATA_W-1:0] raw_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  out_count;
  logic              overflow;

  io_input_capture #(
    .DATA_W          (DATA_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .FIFO_DEPTH      (FIFO_DEPTH)
  ) dut (
    .clock     (clock),
    .init_flag (init_flag),
    .raw_btn   (raw_btn),
    .raw_in    (raw_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int                n_cmp  = 0;
  int                n_fail = 0;
  logic [DATA_W-1:0] sb[$];
  logic              exp_ovf = 1'b0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare all observable FIFO outputs against the scoreboard.
  task automatic check_model(input string tag);
    check({tag, " count"}, 32'(out_count), 32'(sb.size()));
    check({tag, " valid"}, 32'(out_valid), 32'(sb.size() != 0));
    check({tag, " data"}, 32'(out_data), (sb.size() != 0) ? 32'(sb[0]) : 32'd0);
    check({tag, " ovf"}, 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic do_reset();
    init_flag = 1'b1;
    raw_btn   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    init_flag = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
  endtask

  // Clean press/release with out_ready low; updates the scoreboard.
  task automatic press(input logic [DATA_W-1:0] v);
    raw_in  = v;
    raw_btn = 1'b1;
    repeat (HOLD) tick();
    raw_btn = 1'b0;
    repeat (SETTLE) tick();
    if (sb.size() < FIFO_DEPTH) sb.push_back(v);
    else exp_ovf = 1'b1;
  endtask

  task automatic pop_one(input string tag);
    logic [DATA_W-1:0] e;
    if (sb.size() == 0) begin
      check({tag, " unexpected valid"}, 32'(out_valid), 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, " pop data"}, 32'(out_data), 32'(e));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    init_flag = 1'b1;
    raw_btn   = 1'b0;
    raw_in    = '0;
    out_ready = 1'b0;

    // ---------------- reset state ----------------
    do_reset();
    check_model("reset");

    // ---------------- clean press with exact latency ----------------
    raw_in  = 22'h2A5A5;
    raw_btn = 1'b1;
    repeat (DEBOUNCE_CYCLES + 2) tick();          // edges 0 .. D+1
    check("latency before", 32'(out_valid), 32'd0);
    tick();                                       // edge D+2
    sb.push_back(22'h2A5A5);
    check_model("clean press");
    repeat (40 - (DEBOUNCE_CYCLES + 3)) tick();   // hold for 40 cycles total
    raw_btn = 1'b0;
    repeat (SETTLE) tick();
    check_model("clean single push");
    pop_one("clean");
    check_model("clean drained");

    // ---------------- bounce: never stable long enough ----------------
    raw_in = 22'h0F0F0;
    for (int i = 0; i < 4; i++) begin
      raw_btn = 1'b1;
      repeat (5) tick();
      raw_btn = 1'b0;
      tick();
    end
    repeat (SETTLE) tick();
    check_model("bounce");
    // FSM must be back in IDLE: a clean press now gives the full latency.
    raw_in  = 22'h12345;
    raw_btn = 1'b1;
    repeat (DEBOUNCE_CYCLES + 2) tick();
    check("post-bounce latency before", 32'(out_valid), 32'd0);
    tick();
    check("post-bounce latency at", 32'(out_valid), 32'd1);
    raw_btn = 1'b0;
    repeat (SETTLE) tick();

    // ---------------- fill and overflow ----------------
    do_reset();
    for (int v = 1; v <= 8; v++) press(DATA_W'(v));
    check_model("fill 8");
    press(DATA_W'(9));
    check_model("fill 9 overflow");
    for (int k = 0; k < 8; k++) pop_one("fill drain");
    check_model("fill drained sticky ovf");

    // ---------------- full with simultaneous push and pop ----------------
    do_reset();
    for (int v = 1; v <= 8; v++) press(DATA_W'(v));
    check_model("pp full");
    raw_in  = DATA_W'(9);
    raw_btn = 1'b1;
    repeat (DEBOUNCE_CYCLES + 2) tick();
    check("pp head before", 32'(out_data), 32'(sb[0]));
    out_ready = 1'b1;                             // ready during the write edge
    tick();
    out_ready = 1'b0;
    void'(sb.pop_front());
    sb.push_back(DATA_W'(9));
    check_model("pp after");
    raw_btn = 1'b0;
    repeat (SETTLE) tick();
    for (int k = 0; k < 8; k++) pop_one("pp drain");
    check_model("pp drained");

    // ---------------- pointer wrap ----------------
    do_reset();
    for (int v = 0; v < 20; v++) begin
      press(DATA_W'(v * 32'h1111 + 7));
      pop_one("wrap");
    end
    check_model("wrap end");

    // ---------------- reset mid-press ----------------
    do_reset();
    raw_in  = 22'h00155;
    raw_btn = 1'b1;
    repeat (12) tick();                           // WAIT_PRESS with counter 10
    init_flag = 1'b1;
    tick();
    init_flag = 1'b0;
    check_model("midpress reset");
    repeat (DEBOUNCE_CYCLES + 2) tick();
    check("midpress repress before", 32'(out_valid), 32'd0);
    tick();
    sb.push_back(22'h00155);
    check_model("midpress repress");
    raw_btn = 1'b0;
    repeat (SETTLE) tick();
    pop_one("midpress");
    check_model("midpress drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
